// File: rtl/umem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: FSM state codes and transfer owner codes.
package umem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/umem_arbiter_if.sv
// Unified memory port bundle; master is the arbiter side, slave is the memory side.
interface umem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
) ();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdy;

  modport master (
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rdata, mem_rdy
  );

  modport slave (
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rdata, mem_rdy
  );

endinterface

// File: rtl/umem_arbiter_rr2.sv
// Two-way round-robin pick: bit 0 is the I side, bit 1 the D side; a tie goes to the side not served last.
module umem_arbiter_rr2
  import umem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == OWN_I) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/umem_arbiter.sv
// Arbitrates the unified memory port between the I-cache fill path and the D-cache fill/evict path,
// with round-robin grants and a watchdog that aborts stalled transfers.
module umem_arbiter
  import umem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 64,
  parameter int WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] rdata,
  umem_arbiter_if.master    mem
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  arb_state_e       state, state_nxt;
  owner_e           owner_q, rr_last;
  logic             err_flag;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       gnt;
  logic             grant;
  logic             timeout;

  umem_arbiter_rr2 u_rr2 (
    .req  ({d_req, i_req}),
    .last (rr_last),
    .gnt  (gnt)
  );

  assign grant   = (state == ST_IDLE) && (gnt != 2'b00);
  assign timeout = (wait_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (grant) state_nxt = ST_XFER;
      ST_XFER: if (mem.mem_rdy || timeout) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command registers are loaded on grant and the strobes held until the memory answers or the watchdog fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.mem_addr  <= '0;
      mem.mem_re    <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_wdata <= '0;
      rdata         <= '0;
      owner_q       <= OWN_I;
      rr_last       <= OWN_I;
      err_flag      <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner_q  <= gnt[1] ? OWN_D : OWN_I;
            rr_last  <= gnt[1] ? OWN_D : OWN_I;
            wait_cnt <= '0;
            if (gnt[1]) begin
              mem.mem_addr  <= d_addr;
              mem.mem_re    <= ~d_wr;
              mem.mem_we    <= d_wr;
              mem.mem_wdata <= d_wdata;
            end else begin
              mem.mem_addr <= i_addr;
              mem.mem_re   <= 1'b1;
              mem.mem_we   <= 1'b0;
            end
          end
        end
        ST_XFER: begin
          if (mem.mem_rdy) begin
            if (mem.mem_re) rdata <= mem.mem_rdata;
            mem.mem_re <= 1'b0;
            mem.mem_we <= 1'b0;
            err_flag   <= 1'b0;
          end else if (timeout) begin
            mem.mem_re <= 1'b0;
            mem.mem_we <= 1'b0;
            err_flag   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign i_done = (state == ST_RESP) && (owner_q == OWN_I) && !err_flag;
  assign i_err  = (state == ST_RESP) && (owner_q == OWN_I) &&  err_flag;
  assign d_done = (state == ST_RESP) && (owner_q == OWN_D) && !err_flag;
  assign d_err  = (state == ST_RESP) && (owner_q == OWN_D) &&  err_flag;

endmodule
